// File: rtl/d_factor_sched.sv
// d_factor_sched
//   Time-shares one d-factor unit between two sample channels. A channel is
//   granted round-robin, streams BLOCK_LEN samples into the unit (LOAD), and
//   then the block's BLOCK_LEN unit results are forwarded downstream, tagged
//   with the owning channel (DRAIN). Blocks never overlap.
//
// Ports
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   chN_data_i/_valid_i       channel N sample and valid (N = 0, 1)
//   chN_ready_o               channel N sample accepted when valid is high
//   du_data_o, du_dv_o        sample and strobe towards the d-factor unit
//   du_res_i, du_res_dv_i     result and strobe from the d-factor unit
//   res_data_o, res_dv_o      forwarded result and strobe
//   res_ch_o                  channel owning the forwarded result
//   busy_o                    high while loading or draining a block
//   err_o, clr_err_i          sticky protocol-error flag and its clear
module d_factor_sched #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BLOCK_LEN = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] ch0_data_i,
    input  logic              ch0_valid_i,
    output logic              ch0_ready_o,
    input  logic [DATA_W-1:0] ch1_data_i,
    input  logic              ch1_valid_i,
    output logic              ch1_ready_o,
    output logic [DATA_W-1:0] du_data_o,
    output logic              du_dv_o,
    input  logic [DATA_W-1:0] du_res_i,
    input  logic              du_res_dv_i,
    output logic [DATA_W-1:0] res_data_o,
    output logic              res_dv_o,
    output logic              res_ch_o,
    output logic              busy_o,
    output logic              err_o,
    input  logic              clr_err_i
);

    localparam int unsigned       CNT_W    = $clog2(BLOCK_LEN) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN
    } state_e;

    state_e             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [DATA_W-1:0]  du_data_q, du_data_d;
    logic               du_dv_q, du_dv_d;
    logic [DATA_W-1:0]  res_data_q, res_data_d;
    logic               res_dv_q, res_dv_d;
    logic               res_ch_q, res_ch_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               err_set;
    logic               xfer;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            du_data_q    <= '0;
            du_dv_q      <= 1'b0;
            res_data_q   <= '0;
            res_dv_q     <= 1'b0;
            res_ch_q     <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            du_data_q    <= du_data_d;
            du_dv_q      <= du_dv_d;
            res_data_q   <= res_data_d;
            res_dv_q     <= res_dv_d;
            res_ch_q     <= res_ch_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        in_cnt_d     = in_cnt_q;
        out_cnt_d    = out_cnt_q;
        du_data_d    = du_data_q;
        du_dv_d      = 1'b0;
        res_data_d   = res_data_q;
        res_dv_d     = 1'b0;
        res_ch_d     = res_ch_q;
        err_set      = 1'b0;
        // In LOAD only the granted channel is ready, so its valid alone
        // decides whether a transfer happens.
        xfer         = grant_q ? ch1_valid_i : ch0_valid_i;

        unique case (state_q)
            IDLE: begin
                err_set = du_res_dv_i;
                if (ch0_valid_i || ch1_valid_i) begin
                    // On a tie the channel that did not own the last block wins.
                    grant_d = (ch0_valid_i && ch1_valid_i) ? ~last_grant_q : ch1_valid_i;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                err_set = du_res_dv_i;
                if (xfer) begin
                    du_data_d = grant_q ? ch1_data_i : ch0_data_i;
                    du_dv_d   = 1'b1;
                    if (in_cnt_q == LAST_CNT) begin
                        in_cnt_d = '0;
                        state_d  = DRAIN;
                    end else begin
                        in_cnt_d = in_cnt_q + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (du_res_dv_i) begin
                    res_data_d = du_res_i;
                    res_dv_d   = 1'b1;
                    res_ch_d   = grant_q;
                    if (out_cnt_q == LAST_CNT) begin
                        out_cnt_d    = '0;
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end else begin
                        out_cnt_d = out_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A new error wins over a simultaneous clear.
        err_d  = (err_q & ~clr_err_i) | err_set;
        busy_d = (state_d != IDLE);
    end

    // Outputs
    always_comb begin
        ch0_ready_o = (state_q == LOAD) && !grant_q;
        ch1_ready_o = (state_q == LOAD) && grant_q;
        du_data_o   = du_data_q;
        du_dv_o     = du_dv_q;
        res_data_o  = res_data_q;
        res_dv_o    = res_dv_q;
        res_ch_o    = res_ch_q;
        busy_o      = busy_q;
        err_o       = err_q;
    end

endmodule

// File: tb/tb_d_factor_sched.sv
module tb_d_factor_sched;
    localparam int unsigned DW  = 32;
    localparam int unsigned BL4 = 4;
    localparam int unsigned BLB = 1024;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    initial forever #5 clk = ~clk;

    // Instance A: BLOCK_LEN = 4
    logic [DW-1:0] a_d0 = '0, a_d1 = '0, a_res = '0;
    logic          a_v0 = 1'b0, a_v1 = 1'b0, a_rdv = 1'b0, a_clr = 1'b0;
    logic          a_r0, a_r1, a_dudv, a_resdv, a_resch, a_busy, a_err;
    logic [DW-1:0] a_dudata, a_resdata;

    // Instance B: BLOCK_LEN = 1024
    logic [DW-1:0] b_d0 = '0, b_d1 = '0, b_res = '0;
    logic          b_v0 = 1'b0, b_v1 = 1'b0, b_rdv = 1'b0, b_clr = 1'b0;
    logic          b_r0, b_r1, b_dudv, b_resdv, b_resch, b_busy, b_err;
    logic [DW-1:0] b_dudata, b_resdata;

    d_factor_sched #(.DATA_W(DW), .BLOCK_LEN(BL4)) dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .ch0_data_i(a_d0), .ch0_valid_i(a_v0), .ch0_ready_o(a_r0),
        .ch1_data_i(a_d1), .ch1_valid_i(a_v1), .ch1_ready_o(a_r1),
        .du_data_o(a_dudata), .du_dv_o(a_dudv),
        .du_res_i(a_res), .du_res_dv_i(a_rdv),
        .res_data_o(a_resdata), .res_dv_o(a_resdv), .res_ch_o(a_resch),
        .busy_o(a_busy), .err_o(a_err), .clr_err_i(a_clr)
    );

    d_factor_sched #(.DATA_W(DW), .BLOCK_LEN(BLB)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .ch0_data_i(b_d0), .ch0_valid_i(b_v0), .ch0_ready_o(b_r0),
        .ch1_data_i(b_d1), .ch1_valid_i(b_v1), .ch1_ready_o(b_r1),
        .du_data_o(b_dudata), .du_dv_o(b_dudv),
        .du_res_i(b_res), .du_res_dv_i(b_rdv),
        .res_data_o(b_resdata), .res_dv_o(b_resdv), .res_ch_o(b_resch),
        .busy_o(b_busy), .err_o(b_err), .clr_err_i(b_clr)
    );

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic check32(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // Behavioural model of instance A: phase 0 idle, 1 loading, 2 draining.
    int            m_phase = 0, m_in = 0, m_out = 0;
    bit            m_grant = 1'b0, m_last = 1'b1;
    logic          e_du_dv = 1'b0, e_res_dv = 1'b0, e_res_ch = 1'b0, e_busy = 1'b0, e_err = 1'b0;
    logic [DW-1:0] e_du_data = '0, e_res_data = '0;

    always @(posedge clk or negedge rst_n) begin
        bit nerr;
        if (!rst_n) begin
            m_phase = 0; m_in = 0; m_out = 0; m_grant = 1'b0; m_last = 1'b1;
            e_du_dv = 1'b0; e_du_data = '0; e_res_dv = 1'b0; e_res_data = '0;
            e_res_ch = 1'b0; e_busy = 1'b0; e_err = 1'b0;
        end else begin
            nerr = 1'b0;
            e_du_dv = 1'b0;
            e_res_dv = 1'b0;
            if (m_phase == 0) begin
                nerr = a_rdv;
                if (a_v0 || a_v1) begin
                    m_grant = (a_v0 && a_v1) ? !m_last : (a_v1 == 1'b1);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                nerr = a_rdv;
                if (m_grant ? a_v1 : a_v0) begin
                    e_du_dv = 1'b1;
                    e_du_data = m_grant ? a_d1 : a_d0;
                    m_in++;
                    if (m_in == int'(BL4)) begin m_in = 0; m_phase = 2; end
                end
            end else if (a_rdv) begin
                e_res_dv = 1'b1;
                e_res_data = a_res;
                e_res_ch = m_grant;
                m_out++;
                if (m_out == int'(BL4)) begin m_out = 0; m_phase = 0; m_last = m_grant; end
            end
            e_err = (e_err && !a_clr) || nerr;
            e_busy = (m_phase != 0);
        end
    end

    always @(negedge clk) begin
        check1 ("du_dv",     a_dudv,    e_du_dv);
        check32("du_data",   a_dudata,  e_du_data);
        check1 ("res_dv",    a_resdv,   e_res_dv);
        check32("res_data",  a_resdata, e_res_data);
        check1 ("res_ch",    a_resch,   e_res_ch);
        check1 ("busy",      a_busy,    e_busy);
        check1 ("err",       a_err,     e_err);
        check1 ("ch0_ready", a_r0,      (m_phase == 1) && !m_grant);
        check1 ("ch1_ready", a_r1,      (m_phase == 1) && m_grant);
    end

    // Stimulus state for instance A (written only by the main initial block)
    logic [DW-1:0] res_log[$];
    logic          ch_log[$];
    logic [DW-1:0] uq[$];
    int            dudv_cnt = 0, emit_left = 0;
    int            left0 = 0, left1 = 0, acc0 = 0, gap_at = -1, gap_len = 0;

    // Sources present incrementing samples while they have samples left;
    // the emulated unit returns 10x each sample once a whole block is in.
    task automatic run(input int cycles, input int stop_res);
        int got = 0;
        for (int c = 0; c < cycles; c++) begin
            logic r0, r1;
            @(negedge clk);
            r0 = a_r0;
            r1 = a_r1;
            if (a_dudv) begin uq.push_back(a_dudata * 32'd10); dudv_cnt++; end
            if (a_resdv) begin res_log.push_back(a_resdata); ch_log.push_back(a_resch); got++; end
            @(posedge clk);
            #1;
            if (r0 && a_v0) begin a_d0++; acc0++; left0--; end
            if (r1 && a_v1) begin a_d1++; left1--; end
            if (left0 > 0 && gap_len > 0 && acc0 == gap_at) begin
                a_v0 = 1'b0;
                gap_len--;
            end else begin
                a_v0 = (left0 > 0);
            end
            a_v1 = (left1 > 0);
            if (emit_left == 0 && uq.size() >= BL4) emit_left = BL4;
            if (emit_left > 0) begin
                a_rdv = 1'b1;
                a_res = uq.pop_front();
                emit_left--;
            end else begin
                a_rdv = 1'b0;
            end
            if (stop_res > 0 && got >= stop_res) break;
        end
    endtask

    task automatic clear_logs();
        res_log.delete();
        ch_log.delete();
        dudv_cnt = 0;
        acc0 = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int bdv, bres, bres_ch1, bres_ok, b_r0_hi, b_emit, b_stage, bleft;
        logic b_prev_busy, b_done;
        logic [DW-1:0] bq[$];

        repeat (2) @(posedge clk);
        #1;
        check1("reset_busy", a_busy, 1'b0);
        check1("reset_ready0", a_r0, 1'b0);
        rst_n = 1'b1;

        // Tie straight after reset: blocks alternate 0,1,0,1
        clear_logs();
        a_d0 = 32'd1; a_d1 = 32'd1001; left0 = 8; left1 = 8;
        a_v0 = 1'b1; a_v1 = 1'b1;
        run(80, 0);
        check32("tie_res_count", DW'(res_log.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < res_log.size()) begin
                int s;
                s = (((i / 4) % 2) == 1 ? 1001 : 1) + (i / 8) * 4 + (i % 4);
                check1 ("tie_res_ch", ch_log[i], ((i / 4) % 2) == 1);
                check32("tie_res_data", res_log[i], DW'(s * 10));
            end
        end

        // Single channel block
        clear_logs();
        a_d0 = 32'd1; left0 = 4; a_v0 = 1'b1;
        run(25, 0);
        check32("single_dudv_count", DW'(dudv_cnt), 32'd4);
        check32("single_res_count", DW'(res_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < res_log.size()) begin
                check32("single_res_data", res_log[i], DW'((i + 1) * 10));
                check1 ("single_res_ch", ch_log[i], 1'b0);
            end
        end
        check1("single_idle_after", a_busy, 1'b0);

        // Stall: valid dropped for 5 cycles after the 2nd sample
        clear_logs();
        a_d0 = 32'd1; left0 = 4; gap_at = 2; gap_len = 5; a_v0 = 1'b1;
        run(35, 0);
        check32("stall_dudv_count", DW'(dudv_cnt), 32'd4);
        check32("stall_res_count", DW'(res_log.size()), 32'd4);
        if (res_log.size() == 4) check32("stall_last_res", res_log[3], 32'd40);
        gap_at = -1;

        // Protocol error: result strobe while loading
        clear_logs();
        a_d0 = 32'd1; left0 = 1; a_v0 = 1'b1;
        run(4, 0);
        check1("err_in_load", a_busy, 1'b1);
        a_rdv = 1'b1; a_res = 32'hDEAD;
        @(posedge clk); #1;
        a_rdv = 1'b0;
        @(negedge clk);
        check1("err_set", a_err, 1'b1);
        check1("err_no_res", a_resdv, 1'b0);
        @(posedge clk); #1;
        a_rdv = 1'b1; a_clr = 1'b1;
        @(posedge clk); #1;
        a_rdv = 1'b0;
        @(negedge clk);
        check1("err_set_beats_clear", a_err, 1'b1);
        @(posedge clk); #1;
        a_clr = 1'b0;
        @(negedge clk);
        check1("err_cleared", a_err, 1'b0);
        @(posedge clk); #1;
        left0 = 3; a_v0 = 1'b1;
        run(25, 0);
        check32("err_block_res_count", DW'(res_log.size()), 32'd4);
        if (res_log.size() == 4) check32("err_block_res0", res_log[0], 32'd10);

        // Reset mid-DRAIN after 2 results
        clear_logs();
        a_d0 = 32'd1; left0 = 4; a_v0 = 1'b1;
        run(30, 2);
        check32("rst_results_before", DW'(res_log.size()), 32'd2);
        rst_n = 1'b0;
        a_rdv = 1'b0; a_v0 = 1'b0; left0 = 0;
        uq.delete(); emit_left = 0;
        repeat (2) begin
            @(negedge clk);
            check1 ("rst_du_dv", a_dudv, 1'b0);
            check32("rst_du_data", a_dudata, 32'd0);
            check1 ("rst_res_dv", a_resdv, 1'b0);
            check32("rst_res_data", a_resdata, 32'd0);
            check1 ("rst_res_ch", a_resch, 1'b0);
            check1 ("rst_busy", a_busy, 1'b0);
            check1 ("rst_ready0", a_r0, 1'b0);
            check1 ("rst_ready1", a_r1, 1'b0);
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        clear_logs();
        a_d0 = 32'd1; a_d1 = 32'd1001; left0 = 4; left1 = 4;
        a_v0 = 1'b1; a_v1 = 1'b1;
        run(40, 0);
        check32("post_rst_res_count", DW'(res_log.size()), 32'd8);
        if (res_log.size() == 8) begin
            check1 ("post_rst_first_ch", ch_log[0], 1'b0);
            check32("post_rst_first_data", res_log[0], 32'd10);
            check1 ("post_rst_second_ch", ch_log[4], 1'b1);
            check32("post_rst_second_data", res_log[4], 32'd10010);
        end

        // Full 1024-sample block on ch1, ch0 idle
        bdv = 0; bres = 0; bres_ch1 = 0; bres_ok = 0; b_r0_hi = 0; b_emit = 0; b_stage = 0;
        b_done = 1'b0; b_prev_busy = 1'b0;
        b_d1 = 32'd1; bleft = BLB; b_v1 = 1'b1;
        for (int c = 0; c < 2300; c++) begin
            logic r1;
            @(negedge clk);
            r1 = b_r1;
            if (b_r0) b_r0_hi++;
            if (b_dudv) begin bq.push_back(b_dudata + 32'd7); bdv++; end
            if (b_resdv) begin
                bres++;
                if (b_resch) bres_ch1++;
                if (b_resdata == DW'(bres + 7)) bres_ok++;
            end
            if (b_stage == 1) begin
                check1("big_busy_before_last", b_busy, 1'b1);
                b_stage = 2;
            end else if (b_stage == 2) begin
                check1("big_busy_fall", b_busy, 1'b0);
                check1("big_busy_prev", b_prev_busy, 1'b1);
                b_done = 1'b1;
            end
            b_prev_busy = b_busy;
            @(posedge clk); #1;
            if (r1 && b_v1) begin b_d1++; bleft--; end
            b_v1 = (bleft > 0);
            if (b_emit == 0 && bq.size() == BLB) b_emit = BLB;
            if (b_emit > 0) begin
                b_rdv = 1'b1;
                b_res = bq.pop_front();
                b_emit--;
                if (b_emit == 0) b_stage = 1;
            end else begin
                b_rdv = 1'b0;
            end
            if (b_done) break;
        end
        b_rdv = 1'b0;
        check1 ("big_completed", b_done, 1'b1);
        check32("big_dudv_count", DW'(bdv), 32'd1024);
        check32("big_res_count", DW'(bres), 32'd1024);
        check32("big_res_ch1", DW'(bres_ch1), 32'd1024);
        check32("big_res_data_ok", DW'(bres_ok), 32'd1024);
        check32("big_ch0_ready_high", DW'(b_r0_hi), 32'd0);
        check1 ("big_err", b_err, 1'b0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/d_factor_sched.md
D_FACTOR_SCHED -- requirements
Module: d_factor_sched

Interface
REQ-001 Parameter DATA_W, 32, sample and result width in bits.
REQ-002 Parameter BLOCK_LEN, 1024, samples per block; legal range 2..1024.
REQ-003 clock  input  1  single system clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ch0_data  input  DATA_W  channel 0 squared-magnitude sample.
REQ-006 ch0_valid  input  1  channel 0 sample valid.
REQ-007 ch0_ready  output  1  channel 0 sample accepted this cycle when ch0_valid is high.
REQ-008 ch1_data / ch1_valid / ch1_ready  input / input / output  DATA_W / 1 / 1  channel 1 equivalents of REQ-005..REQ-007.
REQ-009 du_data  output  DATA_W  sample driven to the shared d-factor unit data_in.
REQ-010 du_dv  output  1  one-cycle strobe qualifying du_data.
REQ-011 du_res  input  DATA_W  d-factor unit data_out.
REQ-012 du_res_dv  input  1  d-factor unit dv_out.
REQ-013 res_data  output  DATA_W  normalised result forwarded downstream.
REQ-014 res_dv  output  1  one-cycle strobe qualifying res_data.
REQ-015 res_ch  output  1  channel that owns the result qualified by res_dv.
REQ-016 busy  output  1  high in the LOAD and DRAIN states.
REQ-017 err  output  1  sticky protocol-error flag.
REQ-018 clr_err  input  1  synchronous clear of err.

Function
REQ-019 A transfer SHALL occur on chN only in a cycle where chN_valid and chN_ready are both high.
REQ-020 The FSM SHALL have exactly 3 states: IDLE, LOAD and DRAIN.
REQ-021 In IDLE, if any chN_valid is high, the FSM SHALL register the grant and enter LOAD on the next cycle; no sample is accepted in IDLE.
REQ-022 Grant arbitration SHALL be round-robin.
  - Only one channel valid: grant that channel.
  - Both channels valid: grant the channel other than last_grant.
  - last_grant resets to 1, so channel 0 wins the first tie.
REQ-023 In LOAD, chN_ready SHALL equal (grant==N); the non-granted ready and all readys outside LOAD SHALL be 0.
REQ-024 Each LOAD transfer SHALL register du_data and pulse du_dv exactly 1 cycle after the transfer.
REQ-025 Each LOAD transfer SHALL increment the input counter.
REQ-026 On the transfer that brings the input count to BLOCK_LEN, the FSM SHALL enter DRAIN and clear the input counter.
REQ-027 In LOAD, valid gaps on the granted channel SHALL stall the block; no timeout and no channel switch are allowed mid-block.
REQ-028 In DRAIN, each du_res_dv SHALL produce res_data=du_res, res_dv=1 and res_ch=grant exactly 1 cycle later.
REQ-029 Each DRAIN du_res_dv SHALL increment the output counter.
REQ-030 On the du_res_dv that brings the output count to BLOCK_LEN, the FSM SHALL:
  - enter IDLE;
  - set last_grant to grant;
  - clear the output counter.
  The res_dv for that last result is still issued.
REQ-031 A du_res_dv in IDLE or LOAD SHALL set err and SHALL NOT produce res_dv.
REQ-032 err SHALL clear when clr_err is high.
REQ-033 If clr_err is high in the same cycle as a new error, err SHALL stay set.
REQ-034 Counters SHALL be clog2(BLOCK_LEN)+1 bits wide and SHALL never wrap within a block.
REQ-035 The block SHALL accept a new grant only after the full DRAIN of the previous block; there is no overlap of blocks.
REQ-036 busy SHALL be a registered decode of the state.

Reset
REQ-037 While reset is low, the block SHALL set:
  - state to IDLE;
  - grant=0 and last_grant=1;
  - both counters to 0;
  - du_data=0 and du_dv=0;
  - res_data=0, res_dv=0 and res_ch=0;
  - busy=0 and err=0;
  - ch0_ready=0 and ch1_ready=0.
REQ-038 Reset asserted mid-LOAD or mid-DRAIN SHALL abandon the block.
REQ-039 After reset deasserts, the block SHALL ignore outputs of the unit for the abandoned block and flag them per REQ-031; the system is expected to reset the unit together with this block.

Verification
REQ-040 Single channel, BLOCK_LEN=4:
  - stimulus: ch0 valid continuously with data 1,2,3,4; unit returns 10,20,30,40;
  - required: du_dv pulses 4 times, 1 cycle after each transfer; res_data 10,20,30,40 with res_ch=0; ch0_ready=0 throughout DRAIN; IDLE afterwards.
REQ-041 Tie at reset:
  - stimulus: ch0 and ch1 both valid continuously;
  - required: blocks alternate 0,1,0,1; ch1_ready never high while grant=0.
REQ-042 Stall:
  - stimulus: the granted channel drops valid for 5 cycles after the 2nd sample;
  - required: input count holds at 2; no du_dv in the gap; the block completes after valid returns.
REQ-043 Protocol error:
  - stimulus: du_res_dv pulsed while in LOAD;
  - required: err=1 next cycle; no res_dv; err clears the cycle after clr_err=1.
REQ-044 Reset mid-DRAIN:
  - stimulus: reset low for 2 cycles after 2 of 4 results;
  - required: all outputs at reset values during reset; state IDLE; the next tie is granted to ch0.
REQ-045 Boundary, BLOCK_LEN=1024:
  - stimulus: full block on ch1 with ch0 idle;
  - required: exactly 1024 du_dv and 1024 res_dv with res_ch=1; no counter wrap; busy falls 1 cycle after the last du_res_dv.
